// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester bus arbiter.
package arb_pkg;

  localparam int unsigned N_REQ          = 4;
  localparam int unsigned SEL_W          = 2;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned TENURE_MAX_DEF = 8;
  localparam int unsigned TENURE_W       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary owner index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// (with wrap) from the start index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Priority scan; the 2-bit candidate index wraps naturally.
  always_comb begin
    valid = 1'b0;
    idx   = start;
    cand  = start;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = start + SEL_W'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with registered grant, owner index
// and one-cycle-latency data path.
// Optional feature: define ARB_TIMEOUT_EN to bound an owner's tenure to
// TENURE_MAX cycles while other requesters are waiting.
module bus_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TENURE_MAX = TENURE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [N_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_valid,
  output logic              busy
);

  arb_state_t        state;
  arb_state_t        state_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [SEL_W-1:0]  sel_d;
  logic [SEL_W-1:0]  last_owner;
  logic [SEL_W-1:0]  last_owner_d;
  logic              busy_d;
  logic              new_owner;
  logic              release_bus;
  logic              timeout_hit;
  logic [SEL_W-1:0]  pick_start;
  logic              pick_valid;
  logic [SEL_W-1:0]  pick_idx;
  logic [DATA_W-1:0] owner_data;

  // Scan starts after the current owner while granted, after the last owner when idle.
  assign pick_start = (state == GRANT) ? (sel + SEL_W'(1)) : (last_owner + SEL_W'(1));

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner gives up the bus when it drops its request or its tenure expires with others waiting.
  assign release_bus = !req[sel] || (timeout_hit && (|(req & ~gnt)));

  // Next-state, grant and owner-index logic.
  always_comb begin
    state_d      = state;
    gnt_d        = gnt;
    sel_d        = sel;
    last_owner_d = last_owner;
    new_owner    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d   = GRANT;
          new_owner = 1'b1;
        end
      end
      GRANT: begin
        if (release_bus) begin
          last_owner_d = sel;
          if (pick_valid) begin
            new_owner = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (new_owner) begin
      gnt_d = sel_to_onehot(pick_idx);
      sel_d = pick_idx;
    end
  end

  assign busy_d = (state_d == GRANT);

  // Arbitration state and registered grant outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      sel        <= '0;
      last_owner <= SEL_W'(N_REQ - 1);
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      sel        <= sel_d;
      last_owner <= last_owner_d;
      busy       <= busy_d;
    end
  end

  // Shared 4:1 data select driven by the owner index.
  always_comb begin
    case (sel)
      2'd0:    owner_data = din0;
      2'd1:    owner_data = din1;
      2'd2:    owner_data = din2;
      default: owner_data = din3;
    endcase
  end

  // Capture the owner's data one cycle after grant; hold the last word when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_dout  <= '0;
      bus_valid <= 1'b0;
    end else if (|gnt) begin
      bus_dout  <= owner_data;
      bus_valid <= 1'b1;
    end else begin
      bus_valid <= 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [TENURE_W-1:0] TENURE_LIMIT = TENURE_W'(TENURE_MAX);

  logic [TENURE_W-1:0] tenure;
  logic [TENURE_W-1:0] tenure_d;

  // Consecutive grant cycles of the current owner, saturating at the limit.
  always_comb begin
    tenure_d = tenure;
    if (state_d != GRANT) begin
      tenure_d = '0;
    end else if (new_owner) begin
      tenure_d = TENURE_W'(1);
    end else if (tenure != TENURE_LIMIT) begin
      tenure_d = tenure + TENURE_W'(1);
    end
  end

  // Tenure counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tenure <= '0;
    end else begin
      tenure <= tenure_d;
    end
  end

  assign timeout_hit = (tenure == TENURE_LIMIT);
`else
  logic unused_tenure;
  assign unused_tenure = ^TENURE_W'(TENURE_MAX);
  assign timeout_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: a cycle model pushes expected outputs
// per driven cycle, popped and compared after the following clock edge.
module tb_bus_arbiter4;

  localparam int unsigned DW   = 8;
  localparam int unsigned TMAX = 8;

  logic          clk;
  logic          reset_n;
  logic [3:0]    req;
  logic [DW-1:0] din0, din1, din2, din3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] bus_dout;
  logic          bus_valid;
  logic          busy;

  bus_arbiter4 #(.DATA_W(DW), .TENURE_MAX(TMAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .gnt       (gnt),
    .sel       (sel),
    .bus_dout  (bus_dout),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          valid;
    logic          busy;
  } exp_t;

  exp_t          sb_q[$];
  int            checks;
  int            failures;

  // Reference model state
  int            m_owner;
  int            m_last;
  int            m_ten;
  int            m_sel;
  logic [DW-1:0] m_dout;

  logic [DW-1:0] pin2;
  bit            pin2_en;

  // Scenario bookkeeping
  int            seq[$];
  int            runs[$];
  int            owners[$];
  int            exp_order[5];
  int            cnt, prev, idle, run, cur;
  logic [3:0]    r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input logic [3:0] rq, input int start);
    for (int i = 0; i < 4; i++) begin
      if (rq[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_ten   = 0;
    m_sel   = 0;
    m_dout  = '0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, compare.
  task automatic step(input logic [3:0] rq);
    logic [DW-1:0] d [4];
    exp_t e;
    int   w;
    bit   rel;
    for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
    if (pin2_en) d[2] = pin2;
    req  = rq;
    din0 = d[0];
    din1 = d[1];
    din2 = d[2];
    din3 = d[3];

    e.valid = (m_owner >= 0);
    if (m_owner >= 0) m_dout = d[m_owner];

    if (m_owner < 0) begin
      w = rr(rq, (m_last + 1) % 4);
      if (w >= 0) begin
        m_owner = w;
        m_ten   = 1;
      end
    end else begin
      rel = !rq[m_owner];
`ifdef ARB_TIMEOUT_EN
      if (m_ten == int'(TMAX) && (rq & ~(4'b0001 << m_owner)) != 4'b0000) rel = 1'b1;
`endif
      if (rel) begin
        m_last = m_owner;
        w = rr(rq, (m_owner + 1) % 4);
        if (w >= 0) begin
          m_owner = w;
          m_ten   = 1;
        end else begin
          m_owner = -1;
          m_ten   = 0;
        end
      end else if (m_ten < int'(TMAX)) begin
        m_ten++;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;

    e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.dout = m_dout;
    e.busy = (m_owner >= 0);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("gnt",     32'(gnt),       32'(e.gnt));
    check("sel",     32'(sel),       32'(e.sel));
    check("dout",    32'(bus_dout),  32'(e.dout));
    check("valid",   32'(bus_valid), 32'(e.valid));
    check("busy",    32'(busy),      32'(e.busy));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_sel",   32'(sel),       32'd0);
    check("rst_dout",  32'(bus_dout),  32'd0);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    req      = '0;
    din0     = '0;
    din1     = '0;
    din2     = '0;
    din3     = '0;
    pin2     = '0;
    pin2_en  = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    exp_order = '{0, 1, 2, 3, 0};
    #2;

    // Single requester 2 with fixed data
    do_reset();
    pin2_en = 1'b1;
    pin2    = 8'hA5;
    step(4'b0100);
    check("r28_gnt", 32'(gnt), 32'h4);
    step(4'b0100);
    check("r28_valid", 32'(bus_valid), 32'd1);
    check("r28_dout",  32'(bus_dout),  32'hA5);
    check("r28_sel",   32'(sel),       32'd2);
    step(4'b0100);
    pin2_en = 1'b0;

    // All requesting, each owner drops after two grant cycles
    do_reset();
    seq.delete();
    cnt  = 0;
    prev = -1;
    idle = 0;
    for (int c = 0; c < 12 && seq.size() < 5; c++) begin
      r = 4'b1111;
      if (prev >= 0 && cnt == 2) r[prev] = 1'b0;
      step(r);
      if (gnt == 4'b0000) begin
        idle++;
      end else if (int'(sel) != prev) begin
        seq.push_back(int'(sel));
        prev = int'(sel);
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
    check("rr_len", 32'(seq.size()), 32'd5);
    for (int i = 0; i < seq.size() && i < 5; i++) check("rr_order", 32'(seq[i]), 32'(exp_order[i]));
    check("rr_no_idle", 32'(idle), 32'd0);

    // Handover to a lone requester, then drain to idle
    step(4'b0010);
    check("r30_gnt1", 32'(gnt), 32'h2);
    step(4'b0010);
    step(4'b0001);
    check("r30_hand", 32'(gnt), 32'h1);
    step(4'b0000);
    check("r30_idle", 32'(gnt), 32'h0);
    step(4'b0000);
    check("r30_valid0", 32'(bus_valid), 32'd0);
    check("r30_busy0",  32'(busy),      32'd0);

    // Reset in the middle of requester 3's tenure
    do_reset();
    step(4'b1000);
    step(4'b1000);
    step(4'b1000);
    check("r31_gnt", 32'(gnt), 32'h8);
    do_reset();
    step(4'b1000);
    check("r31_regnt", 32'(gnt), 32'h8);
    step(4'b1000);
    check("r31_valid", 32'(bus_valid), 32'd1);

    // Random request traffic
    for (int c = 0; c < 80; c++) begin
      if (($urandom % 3) != 0) r = 4'($urandom);
      step(r);
    end

`ifdef ARB_TIMEOUT_EN
    // Two requesters held continuously alternate every TENURE_MAX cycles
    do_reset();
    runs.delete();
    owners.delete();
    run = 0;
    cur = -1;
    for (int c = 0; c < 34; c++) begin
      step(4'b0011);
      if (int'(sel) != cur) begin
        if (cur >= 0) runs.push_back(run);
        owners.push_back(int'(sel));
        cur = int'(sel);
        run = 1;
      end else begin
        run++;
      end
    end
    if (runs.size() >= 2 && owners.size() >= 2) begin
      check("to_run0",   32'(runs[0]),   32'(TMAX));
      check("to_run1",   32'(runs[1]),   32'(TMAX));
      check("to_owner0", 32'(owners[0]), 32'd0);
      check("to_owner1", 32'(owners[1]), 32'd1);
    end else begin
      check("to_runs", 32'(runs.size()), 32'd2);
    end
    // A lone requester keeps the bus past the limit
    cnt = 0;
    for (int c = 0; c < 22; c++) begin
      step(4'b0001);
      if (gnt == 4'b0001) cnt++;
    end
    check("to_solo", 32'(cnt >= 20), 32'd1);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter DATA_W, default 8, width of each requester data bus and of bus_dout.
REQ-002 Parameter TENURE_MAX, default 8, maximum consecutive grant cycles when ARB_TIMEOUT_EN is defined (legal range 2..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  4  request per requester, level-sensitive; bit i = requester i.
REQ-006 din0..din3  input  DATA_W each  requester data, selected by current owner.
REQ-007 gnt  output  4  one-hot grant, registered; all-zero when bus idle.
REQ-008 sel  output  2  binary index of current owner, registered; drives the shared 4:1 datapath mux select.
REQ-009 bus_dout  output  DATA_W  registered copy of the owner's data.
REQ-010 bus_valid  output  1  high when bus_dout carries owner data.
REQ-011 busy  output  1  high in state GRANT.

Function
REQ-012 States: IDLE (no owner), GRANT (one owner); encoding from shared package.
REQ-013 IDLE: if req != 0 at edge k, go to GRANT at k+1 with gnt = winner; else stay IDLE with gnt = 0.
REQ-014 Winner: first set bit of req scanning round-robin from (last_owner+1) mod 4; last_owner resets to 3, so first pick after reset favours requester 0.
REQ-015 GRANT: owner keeps the bus while req[owner] = 1; no preemption except REQ-023.
REQ-016 Release: if req[owner] = 0 at edge k, then at k+1 gnt moves directly to next round-robin winner from owner+1 (zero-gap handover) or, if none pending, state goes IDLE with gnt = 0.
REQ-017 last_owner updates to owner on every release.
REQ-018 gnt is exactly one-hot in GRANT and zero in IDLE; sel equals index of set gnt bit, holds last value in IDLE.
REQ-019 Data latency 1: if gnt[i] = 1 at cycle k, then at k+1 bus_dout = din_i sampled at k and bus_valid = 1; else bus_valid = 0 and bus_dout holds.
REQ-020 Requests from non-owners while GRANT only affect the next winner; a request raised and dropped within one owner's tenure is not remembered.
REQ-021 Simultaneous owner release and new requests: resolved by REQ-016 in the same edge; no idle cycle inserted.

Reset
REQ-022 reset_n low forces immediately: state IDLE, gnt = 0, sel = 0, bus_dout = 0, bus_valid = 0, busy = 0, last_owner = 3, tenure counter = 0; reset mid-grant drops the grant without handover; first arbitration occurs on the first rising edge after deassertion.

Configuration
REQ-023 With macro ARB_TIMEOUT_EN defined: tenure counter counts owner's consecutive grant cycles; when it reaches TENURE_MAX and any other req bit is set, owner is forced to release at the next edge per REQ-016; if no other request, counter saturates and owner keeps bus.
REQ-024 Without ARB_TIMEOUT_EN: no tenure counter is built; tenure unlimited.

Structure
REQ-025 Shared package arb_pkg holds state typedef (IDLE, GRANT), N_REQ = 4, SEL_W = 2, default DATA_W and TENURE_MAX constants.
REQ-026 One sub-module rr_pick: combinational round-robin picker, inputs req[3:0] and start index, outputs valid and 2-bit index; instantiated once.
REQ-027 The data select inside bus_arbiter4 is a 4:1 mux on sel; no other sub-modules.

Verification
REQ-028 Reset then req = 4'b0100 held 3 cycles, din2 = 8'hA5 -> gnt = 4'b0100 one edge later, bus_valid and bus_dout = 8'hA5 the following edge, sel = 2.
REQ-029 req = 4'b1111 with each owner dropping after 2 cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
REQ-030 Owner 1 drops req while req = 4'b0001 -> next gnt = 4'b0001; then all req low -> IDLE, gnt = 0, bus_valid = 0 one cycle after.
REQ-031 reset_n pulsed low mid-grant of requester 3 -> gnt = 0, bus_valid = 0 immediately, without waiting for clk; after release with req = 4'b1000, requester 3 regranted.
REQ-032 ARB_TIMEOUT_EN, TENURE_MAX = 8, req = 4'b0011 held -> owner 0 for 8 cycles, then owner 1 for 8, alternating; with req = 4'b0001 alone, owner 0 keeps bus 20+ cycles.
REQ-033 Assertion throughout all scenarios: gnt one-hot or zero, sel consistent with gnt, busy equals |gnt.
